// File: rtl/rv16_rf_read_stage.sv
// rv16_rf_read_stage: 16-entry register file read stage with writeback bypass and stall-coherent operands
module rv16_rf_read_stage #(
  parameter int DATA = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_wb_en,
  input  logic [3:0]      rd_wb_addr,
  input  logic [DATA-1:0] rd_wb_in,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [3:0]      rs1_addr,
  input  logic [3:0]      rs2_addr,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [DATA-1:0] rs1_data,
  output logic [DATA-1:0] rs2_data
);
  logic [DATA-1:0] rf [16];
  logic [3:0] lat1, lat2;
  logic wb, accept, transfer;
  logic [DATA-1:0] cap1, cap2;
  assign id_ready = !ex_valid || ex_ready;
  assign accept = id_valid && id_ready;
  assign transfer = ex_valid && ex_ready;
  assign wb = rd_wb_en && rd_wb_addr != 4'd0;
  assign cap1 = rs1_addr == 4'd0 ? '0 : wb && rd_wb_addr == rs1_addr ? rd_wb_in : rf[rs1_addr];
  assign cap2 = rs2_addr == 4'd0 ? '0 : wb && rd_wb_addr == rs2_addr ? rd_wb_in : rf[rs2_addr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      ex_valid <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
      lat1 <= 4'd0;
      lat2 <= 4'd0;
    end else begin
      if (wb) rf[rd_wb_addr] <= rd_wb_in;
      if (accept) begin
        ex_valid <= 1'b1;
        lat1 <= rs1_addr;
        lat2 <= rs2_addr;
        rs1_data <= cap1;
        rs2_data <= cap2;
      end else if (transfer) begin
        ex_valid <= 1'b0;
      end else if (ex_valid) begin
        if (wb && lat1 == rd_wb_addr) rs1_data <= rd_wb_in;
        if (wb && lat2 == rd_wb_addr) rs2_data <= rd_wb_in;
      end
    end
  end
endmodule

// File: tb/tb_rv16_rf_read_stage.sv
// tb_rv16_rf_read_stage: directed and randomized check of rv16_rf_read_stage against an architectural model
module tb_rv16_rf_read_stage;
  logic clk = 1'b0;
  logic rst_n, rd_wb_en, id_valid, ex_ready, id_ready, ex_valid;
  logic [3:0] rd_wb_addr, rs1_addr, rs2_addr;
  logic [15:0] rd_wb_in, rs1_data, rs2_data;
  int checks = 0;
  int failures = 0;
  logic [15:0] m_rf [16];
  logic m_valid = 1'b0;
  logic [3:0] m_l1 = 4'd0, m_l2 = 4'd0;
  logic [15:0] m_f1 = 16'd0, m_f2 = 16'd0;
  always #5 clk = ~clk;
  rv16_rf_read_stage dut (
    .clk(clk), .rst_n(rst_n), .rd_wb_en(rd_wb_en), .rd_wb_addr(rd_wb_addr), .rd_wb_in(rd_wb_in),
    .id_valid(id_valid), .id_ready(id_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] arch(input logic [3:0] a);
    return a == 4'd0 ? 16'd0 : m_rf[a];
  endfunction
  function automatic logic [15:0] expect_op(input logic [3:0] l, input logic [15:0] f);
    return m_valid ? arch(l) : f;
  endfunction
  task automatic step();
    logic [15:0] p1, p2;
    logic acc, xfer;
    #1 chk("id_ready", id_ready, !m_valid || ex_ready);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
      m_valid = 1'b0;
      m_l1 = 4'd0;
      m_l2 = 4'd0;
      m_f1 = 16'd0;
      m_f2 = 16'd0;
    end else begin
      p1 = expect_op(m_l1, m_f1);
      p2 = expect_op(m_l2, m_f2);
      acc = id_valid && (!m_valid || ex_ready);
      xfer = m_valid && ex_ready;
      if (rd_wb_en && rd_wb_addr != 4'd0) m_rf[rd_wb_addr] = rd_wb_in;
      if (acc) begin
        m_valid = 1'b1;
        m_l1 = rs1_addr;
        m_l2 = rs2_addr;
      end else if (xfer) begin
        m_valid = 1'b0;
        m_f1 = p1;
        m_f2 = p2;
      end
    end
    #1;
    chk("ex_valid", ex_valid, m_valid);
    chk("rs1_data", rs1_data, expect_op(m_l1, m_f1));
    chk("rs2_data", rs2_data, expect_op(m_l2, m_f2));
  endtask
  task automatic cyc(input logic rn, input logic iv, input logic [3:0] a1, input logic [3:0] a2,
                     input logic er, input logic we, input logic [3:0] wa, input logic [15:0] wd);
    rst_n = rn;
    id_valid = iv;
    rs1_addr = a1;
    rs2_addr = a2;
    ex_ready = er;
    rd_wb_en = we;
    rd_wb_addr = wa;
    rd_wb_in = wd;
    step();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 16'd0;
    cyc(0, 0, 0, 0, 1, 0, 0, 16'd0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    cyc(1, 0, 0, 0, 1, 1, 5, 16'hA5A5);
    cyc(1, 1, 5, 0, 1, 0, 0, 16'd0);
    chk("tp_x5_rs1", rs1_data, 16'hA5A5);
    chk("tp_x5_rs2", rs2_data, 16'h0000);
    cyc(1, 0, 0, 0, 1, 1, 0, 16'hFFFF);
    cyc(1, 1, 0, 0, 1, 0, 0, 16'd0);
    chk("tp_x0_rs1", rs1_data, 16'h0000);
    chk("tp_x0_rs2", rs2_data, 16'h0000);
    cyc(1, 1, 3, 3, 1, 1, 3, 16'h1234);
    chk("tp_byp_rs1", rs1_data, 16'h1234);
    chk("tp_byp_rs2", rs2_data, 16'h1234);
    cyc(1, 1, 3, 0, 1, 0, 0, 16'd0);
    chk("tp_byp_rf", rs1_data, 16'h1234);
    cyc(1, 0, 0, 0, 1, 1, 7, 16'h0001);
    cyc(1, 1, 7, 0, 0, 0, 0, 16'd0);
    chk("tp_stall_cap", rs1_data, 16'h0001);
    chk("tp_stall_id_ready", id_ready, 0);
    cyc(1, 1, 9, 9, 0, 1, 7, 16'h0BEE);
    chk("tp_stall_coh", rs1_data, 16'h0BEE);
    chk("tp_stall_valid", ex_valid, 1);
    cyc(1, 0, 0, 0, 1, 0, 0, 16'd0);
    chk("tp_xfer_valid", ex_valid, 0);
    chk("tp_xfer_id_ready", id_ready, 1);
    cyc(1, 0, 0, 0, 1, 1, 7, 16'h7777);
    chk("tp_idle_hold", rs1_data, 16'h0BEE);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 0, 1, 1, 4'(i), 16'(i * 16'h0101));
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 1, 4'(i), 0, 1, 0, 0, 16'd0);
      chk("tp_b2b_valid", ex_valid, 1);
      chk("tp_b2b_rs1", rs1_data, 16'(i * 16'h0101));
    end
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 49) != 0, 1'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 9) < 6, 1'($urandom), 4'($urandom), 16'($urandom));
    cyc(1, 0, 0, 0, 1, 1, 9, 16'h9999);
    cyc(1, 1, 9, 9, 0, 0, 0, 16'd0);
    cyc(1, 1, 1, 2, 0, 0, 0, 16'd0);
    chk("tp_rst_pre", rs1_data, 16'h9999);
    cyc(0, 1, 9, 9, 0, 1, 9, 16'h5555);
    chk("tp_rst_valid", ex_valid, 0);
    chk("tp_rst_rs1", rs1_data, 16'h0000);
    chk("tp_rst_rs2", rs2_data, 16'h0000);
    chk("tp_rst_id_ready", id_ready, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 4'(i), 4'(15 - i), 1, 0, 0, 16'd0);
      chk("tp_rst_rf1", rs1_data, 16'h0000);
      chk("tp_rst_rf2", rs2_data, 16'h0000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
